ems_cfg_master: RTL and testbench

//  Wishbone classic master that programs the EMS page-mapping register file:

---
 rtl/ems_pkg.sv | 37 +++
 rtl/ems_wb_xfer.sv | 56 +++++
 rtl/ems_cfg_master.sv | 188 ++++++++++++++++++
 tb/tb_ems_cfg_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ems_pkg.sv
// Shared EMS register-file definitions: byte indices, programming order and
// sequencer state encoding, reused by the EMS slave and its benches.
package ems_pkg;

    localparam int         NUM_REGS    = 6;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_BASE    = 3'd1;
    localparam logic [2:0] REG_PAGE0   = 3'd2;
    localparam logic [2:0] IDX_LAST    = 3'(NUM_REGS - 1);
    localparam int         CTRL_EN_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WGAP,
        ST_RD,
        ST_RGAP,
        ST_DONE
    } state_e;

    // Pages first, then base, enable last so the mapping is complete when it goes live.
    function automatic logic [2:0] wr_order(input logic [2:0] idx);
        case (idx)
            3'd0:    return REG_PAGE0;
            3'd1:    return REG_PAGE0 + 3'd1;
            3'd2:    return REG_PAGE0 + 3'd2;
            3'd3:    return REG_PAGE0 + 3'd3;
            3'd4:    return REG_BASE;
            default: return REG_CTRL;
        endcase
    endfunction

    function automatic logic [1:0] reg_sel(input logic [2:0] k);
        return k[0] ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ems_wb_xfer.sv
// Single Wishbone classic access: strobes while req_i is held, reports the
// acknowledge or an ack timeout back to the sequencer.
module ems_wb_xfer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [1:0]  sel_i,
    input  logic [15:0] dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic        ack_o,
    output logic        tmo_o
);

    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The sequencer always drops req_i for at least one cycle between accesses,
    // so the counter is guaranteed to start from zero on every new access.
    always_comb begin
        cnt_d = '0;
        if (req_i && !wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_cyc_o = req_i;
    assign wb_stb_o = req_i;
    assign wb_we_o  = req_i & we_i;
    assign wb_adr_o = req_i ? adr_i : 2'b00;
    assign wb_sel_o = req_i ? sel_i : 2'b00;
    assign wb_dat_o = req_i ? dat_i : 16'h0000;

    assign ack_o = req_i & wb_ack_i;
    assign tmo_o = req_i & ~wb_ack_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/ems_cfg_master.sv
// Boot-time EMS configurator: snapshots the page map on start, writes it to the
// EMS register file over Wishbone and optionally reads every register back.
module ems_cfg_master #(
    parameter int ACK_TIMEOUT = 16,
    parameter bit VERIFY      = 1'b1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start_i,
    input  logic        ems_en_i,
    input  logic [3:0]  umb_base_i,
    input  logic [7:0]  page0_i,
    input  logic [7:0]  page1_i,
    input  logic [7:0]  page2_i,
    input  logic [7:0]  page3_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_idx_o,
    output logic [1:0]  wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    import ems_pkg::*;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [2:0]  err_idx_q, err_idx_d;
    logic        snap_load;

    logic        en_q;
    logic [3:0]  base_q;
    logic [7:0]  page_q [4];
    logic [7:0]  page_in [4];

    logic        reading;
    logic [2:0]  k;
    logic [1:0]  pidx;
    logic [7:0]  wbyte;
    logic [7:0]  rbyte;
    logic        xfer_req;
    logic        xfer_ack;
    logic        xfer_tmo;

    assign page_in[0] = page0_i;
    assign page_in[1] = page1_i;
    assign page_in[2] = page2_i;
    assign page_in[3] = page3_i;

    // Writes walk the programming order; readback walks registers 0..5 directly.
    assign reading = (state_q == ST_RD) || (state_q == ST_RGAP);
    assign k       = reading ? idx_q : wr_order(idx_q);
    assign pidx    = k[1:0] - 2'd2;

    always_comb begin
        wbyte = 8'h00;
        case (k)
            REG_CTRL: wbyte[CTRL_EN_BIT] = en_q;
            REG_BASE: wbyte = {4'b0000, base_q};
            default:  wbyte = page_q[pidx];
        endcase
    end

    // Only the lane selected by the access carries the register byte.
    assign rbyte    = k[0] ? wb_dat_i[15:8] : wb_dat_i[7:0];
    assign xfer_req = (state_q == ST_WR) || (state_q == ST_RD);

    ems_wb_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .req_i    (xfer_req),
        .we_i     (state_q == ST_WR),
        .adr_i    (k[2:1]),
        .sel_i    (reg_sel(k)),
        .dat_i    ({wbyte, wbyte}),
        .wb_ack_i (wb_ack_i),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .ack_o    (xfer_ack),
        .tmo_o    (xfer_tmo)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        snap_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    state_d   = ST_WR;
                    idx_d     = 3'd0;
                    err_d     = 1'b0;
                    err_idx_d = 3'd0;
                    snap_load = 1'b1;
                end
            end
            ST_WR: begin
                if (xfer_tmo) begin
                    err_d     = 1'b1;
                    err_idx_d = k;
                    state_d   = ST_DONE;
                end else if (xfer_ack) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 3'd0;
                        state_d = VERIFY ? ST_RGAP : ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_WGAP;
                    end
                end
            end
            ST_WGAP: state_d = ST_WR;
            ST_RD: begin
                if (xfer_tmo) begin
                    err_d     = 1'b1;
                    err_idx_d = k;
                    state_d   = ST_DONE;
                end else if (xfer_ack) begin
                    if (rbyte != wbyte) begin
                        err_d     = 1'b1;
                        err_idx_d = k;
                        state_d   = ST_DONE;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_RGAP;
                    end
                end
            end
            ST_RGAP: state_d = ST_RD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            err_q     <= 1'b0;
            err_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            en_q   <= 1'b0;
            base_q <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                page_q[i] <= 8'h00;
            end
        end else if (snap_load) begin
            en_q   <= ems_en_i;
            base_q <= umb_base_i;
            for (int i = 0; i < 4; i++) begin
                page_q[i] <= page_in[i];
            end
        end
    end

    assign busy_o    = (state_q == ST_WR) || (state_q == ST_WGAP) ||
                       (state_q == ST_RD) || (state_q == ST_RGAP);
    assign done_o    = (state_q == ST_DONE);
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_ems_cfg_master.sv
// Randomised bench for ems_cfg_master: a Wishbone slave model with wait states,
// stalls and corrupt readback, checked against a sequence-level reference model.
module tb_ems_cfg_master;

    localparam int ACK_TIMEOUT = 16;
    localparam int NO_K        = 7;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        start_i = 1'b0;
    logic        ems_en_i = 1'b0;
    logic [3:0]  umb_base_i = 4'h0;
    logic [7:0]  page0_i = 8'h00;
    logic [7:0]  page1_i = 8'h00;
    logic [7:0]  page2_i = 8'h00;
    logic [7:0]  page3_i = 8'h00;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  err_idx_o;
    logic [1:0]  wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_dat_i = 16'h0000;
    logic        wb_ack_i = 1'b0;

    ems_cfg_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .VERIFY      (1'b1)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .start_i    (start_i),
        .ems_en_i   (ems_en_i),
        .umb_base_i (umb_base_i),
        .page0_i    (page0_i),
        .page1_i    (page1_i),
        .page2_i    (page2_i),
        .page3_i    (page3_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_idx_o  (err_idx_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 wb_clk = ~wb_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    typedef struct {
        bit         we;
        int         k;
        logic [7:0] dat;
        int         hold;
        bit         ok;
    } xact_t;

    xact_t       log_q[$];
    xact_t       sx;
    int          wait_n = 0;
    int          blk_k  = NO_K;
    int          cor_k  = NO_K;
    bit          in_acc = 1'b0;
    int          left;
    int          hold;
    int          cur_k;
    logic [1:0]  a0, s0;
    logic [15:0] d0;
    logic        we0;
    logic [7:0]  rb;
    logic [7:0]  mem [6];

    always @(negedge wb_clk) begin
        if (wb_rst || !(wb_cyc_o && wb_stb_o)) begin
            wb_ack_i = 1'b0;
            in_acc   = 1'b0;
        end else begin
            if (!in_acc) begin
                in_acc = 1'b1;
                left   = wait_n;
                hold   = 0;
                a0     = wb_adr_o;
                s0     = wb_sel_o;
                d0     = wb_dat_o;
                we0    = wb_we_o;
            end
            hold++;
            cur_k = int'({wb_adr_o, (wb_sel_o == 2'b10)});
            if (cur_k != blk_k && left == 0) begin
                sx.we   = wb_we_o;
                sx.k    = cur_k;
                sx.dat  = (wb_sel_o == 2'b10) ? wb_dat_o[15:8] : wb_dat_o[7:0];
                sx.hold = hold;
                sx.ok   = (wb_sel_o == 2'b01 || wb_sel_o == 2'b10) && a0 == wb_adr_o &&
                          s0 == wb_sel_o && we0 == wb_we_o && cur_k < 6 &&
                          (!wb_we_o || (d0 == wb_dat_o && wb_dat_o[15:8] == wb_dat_o[7:0]));
                if (cur_k < 6) begin
                    if (wb_we_o) begin
                        mem[cur_k] = sx.dat;
                    end else begin
                        rb = (cur_k == cor_k) ? 8'h42 : mem[cur_k];
                        wb_dat_i = (wb_sel_o == 2'b10) ? {rb, ~rb} : {~rb, rb};
                    end
                end
                log_q.push_back(sx);
                wb_ack_i = 1'b1;
                $display("[TB] %s k=%0d byte=%02h hold=%0d", wb_we_o ? "WR" : "RD",
                         cur_k, wb_we_o ? sx.dat : rb, hold);
            end else begin
                if (left > 0) left--;
                wb_ack_i = 1'b0;
            end
        end
    end

    // ---------------- one configuration run against the reference model ----------------
    task automatic run_seq(input int w, input int blk, input int cor, input bit repulse,
                           input logic en, input logic [3:0] base,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] regs [6];
        int         order [6] = '{2, 3, 4, 5, 1, 0};
        bit         ew [$];
        int         ek [$];
        logic [7:0] ed [$];
        int         total = 0;
        int         nacc = 0;
        bit         eerr = 1'b0;
        int         eidx = 0;
        int         edone;
        int         lbase;
        int         c;
        int         rp;
        bit         seen_done;
        bit         busy_ok;
        logic [7:0] got_rd;
        xact_t      x;

        regs[0] = {7'b0, en};
        regs[1] = {4'b0, base};
        regs[2] = p0; regs[3] = p1; regs[4] = p2; regs[5] = p3;
        for (int i = 0; i < 6; i++) begin
            nacc++;
            if (order[i] == blk) begin
                total += ACK_TIMEOUT;
                eerr = 1'b1;
                eidx = order[i];
                break;
            end
            total += w + 1;
            ew.push_back(1'b1); ek.push_back(order[i]); ed.push_back(regs[order[i]]);
        end
        if (!eerr) begin
            for (int j = 0; j < 6; j++) begin
                nacc++;
                total += w + 1;
                got_rd = (j == cor) ? 8'h42 : regs[j];
                ew.push_back(1'b0); ek.push_back(j); ed.push_back(got_rd);
                if (got_rd != regs[j]) begin
                    eerr = 1'b1;
                    eidx = j;
                    break;
                end
            end
        end
        edone = total + (nacc - 1) + 1;

        wait_n = w; blk_k = blk; cor_k = cor;
        lbase  = log_q.size();
        @(negedge wb_clk);
        ems_en_i = en; umb_base_i = base;
        page0_i = p0; page1_i = p1; page2_i = p2; page3_i = p3;
        start_i = 1'b1;
        @(negedge wb_clk);
        start_i = 1'b0;
        ems_en_i = 1'($urandom); umb_base_i = 4'($urandom);
        page0_i = 8'($urandom); page1_i = 8'($urandom);
        page2_i = 8'($urandom); page3_i = 8'($urandom);
        check_eq("busy_c1", 32'(busy_o), 32'd1);
        check_eq("err_clr", 32'(err_o), 32'd0);

        rp = 2 + int'($urandom % 6);
        c = 1; seen_done = 1'b0; busy_ok = 1'b1;
        while (c < 300 && !seen_done) begin
            if (done_o) begin
                seen_done = 1'b1;
            end else begin
                if (!busy_o) busy_ok = 1'b0;
                if (repulse && c == rp) begin
                    start_i  = 1'b1;
                    ems_en_i = ~en;
                    page0_i  = ~p0;
                end
                if (repulse && c == rp + 1) start_i = 1'b0;
                @(negedge wb_clk);
                c++;
            end
        end
        start_i = 1'b0;

        check_eq("done_seen", 32'(seen_done), 32'd1);
        check_eq("done_cycle", c, edone);
        check_eq("busy_at_done", 32'(busy_o), 32'd0);
        check_eq("busy_held", 32'(busy_ok), 32'd1);
        check_eq("err", 32'(err_o), 32'(eerr));
        if (eerr) check_eq("err_idx", 32'(err_idx_o), eidx);
        check_eq("n_xact", log_q.size() - lbase, ek.size());
        for (int i = 0; i < ek.size(); i++) begin
            if (lbase + i < log_q.size()) begin
                x = log_q[lbase + i];
                check_eq("xact_we", 32'(x.we), 32'(ew[i]));
                check_eq("xact_k", x.k, ek[i]);
                check_eq("xact_hold", x.hold, w + 1);
                check_eq("xact_bus_ok", 32'(x.ok), 32'd1);
                if (ew[i]) check_eq("xact_wdata", 32'(x.dat), 32'(ed[i]));
            end
        end
        @(negedge wb_clk);
        check_eq("done_pulse", 32'(done_o), 32'd0);
        check_eq("err_sticky", 32'(err_o), 32'(eerr));
    endtask

    task automatic reset_mid();
        int c;
        bit found;
        wait_n = 0; blk_k = NO_K; cor_k = NO_K;
        @(negedge wb_clk);
        ems_en_i = 1'b1; umb_base_i = 4'hD;
        page0_i = 8'h20; page1_i = 8'h21; page2_i = 8'h22; page3_i = 8'h23;
        start_i = 1'b1;
        @(negedge wb_clk);
        start_i = 1'b0;
        found = 1'b0; c = 0;
        while (!found && c < 50) begin
            if (wb_cyc_o && wb_stb_o && wb_we_o && wb_adr_o == 2'd1 && wb_sel_o == 2'b10)
                found = 1'b1;
            else begin
                @(negedge wb_clk);
                c++;
            end
        end
        check_eq("k3_reached", 32'(found), 32'd1);
        #1 wb_rst = 1'b1;
        #1;
        check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
        check_eq("rst_we", 32'(wb_we_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk);
            check_eq("rst_no_done", 32'(done_o), 32'd0);
            check_eq("rst_idle_busy", 32'(busy_o), 32'd0);
        end
        run_seq(0, NO_K, NO_K, 1'b0, 1'b1, 4'hD, 8'h20, 8'h21, 8'h22, 8'h23);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst = 1'b1;
        repeat (3) @(negedge wb_clk);
        check_eq("rst_outputs",
                 {3'b0, busy_o, done_o, err_o, err_idx_o, wb_adr_o, wb_dat_o,
                  wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        check_eq("idle_busy", 32'(busy_o), 32'd0);

        run_seq(0, NO_K, NO_K, 1'b0, 1'b1, 4'hB, 8'h00, 8'h01, 8'h02, 8'h03);
        run_seq(3, NO_K, NO_K, 1'b0, 1'b1, 4'hB, 8'h00, 8'h01, 8'h02, 8'h03);
        run_seq(0, 4,    NO_K, 1'b0, 1'b1, 4'hB, 8'h00, 8'h01, 8'h02, 8'h03);
        run_seq(0, NO_K, 2,    1'b0, 1'b1, 4'hB, 8'h10, 8'h11, 8'h12, 8'h13);
        run_seq(0, NO_K, NO_K, 1'b1, 1'b0, 4'hC, 8'h5A, 8'hA5, 8'h3C, 8'hC3);
        reset_mid();

        for (int t = 0; t < 20; t++) begin
            run_seq(int'($urandom % 4),
                    ($urandom % 3 == 0) ? int'($urandom % 6) : NO_K,
                    ($urandom % 3 == 0) ? int'($urandom % 6) : NO_K,
                    1'($urandom),
                    1'($urandom), 4'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
